// File: rtl/order_tracker.sv
// rtl/order_tracker.sv - order slot manager with per-slot countdown, serve matching and scoring
module order_tracker #(
   parameter int NUM_ORDERS  = 3,
   parameter int ORDER_WIDTH = 12,
   parameter int TICK_DIV    = 100_000_000,
   parameter int ORDER_TIME  = 60,
   parameter int TIMER_WIDTH = 7,
   parameter int SCORE_WIDTH = 8,
   parameter int BASE_POINTS = 10,
   parameter int PENALTY     = 5,
   parameter int WIN_TARGET  = 5
) (
   input  logic                              basys_clk,
   input  logic                              reset,
   input  logic                              start_game,
   input  logic                              load_valid,
   input  logic [ORDER_WIDTH-1:0]            load_order,
   output logic                              load_ready,
   input  logic                              serve_valid,
   input  logic [ORDER_WIDTH-1:0]            serve_dish,
   output logic                              serve_ack,
   output logic                              serve_hit,
   output logic [NUM_ORDERS*ORDER_WIDTH-1:0] orders_flat,
   output logic [NUM_ORDERS-1:0]             active,
   output logic [NUM_ORDERS*TIMER_WIDTH-1:0] time_left_flat,
   output logic [3:0]                        orders_done,
   output logic [3:0]                        orders_expired,
   output logic [SCORE_WIDTH-1:0]            score,
   output logic                              game_over
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_OVER = 2'd2;

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   // Wide enough that score + base + bonus can never wrap before clamping
   localparam int SUM_W  = SCORE_WIDTH + TIMER_WIDTH + 2;

   localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TIMER_WIDTH-1:0] T_LOAD    = TIMER_WIDTH'(ORDER_TIME);
   localparam logic [SUM_W-1:0]       SCORE_MAX = {{(SUM_W-SCORE_WIDTH){1'b0}}, {SCORE_WIDTH{1'b1}}};
   localparam logic [SUM_W-1:0]       BASE_SUM  = SUM_W'(BASE_POINTS);
   localparam logic [SUM_W-1:0]       PEN_SUM   = SUM_W'(PENALTY);
   localparam logic [3:0]             DONE_WIN  = 4'(WIN_TARGET);

   logic [1:0]                       state_q,   state_d;
   logic [TICK_W-1:0]                tick_q,    tick_d;
   logic [NUM_ORDERS-1:0]            active_q,  active_d;
   logic [NUM_ORDERS*ORDER_WIDTH-1:0] orders_q, orders_d;
   logic [NUM_ORDERS*TIMER_WIDTH-1:0] time_q,   time_d;
   logic [3:0]                       done_q,    done_d;
   logic [3:0]                       expired_q, expired_d;
   logic [SCORE_WIDTH-1:0]           score_q,   score_d;
   logic                             ack_q,     ack_d;
   logic                             hit_q,     hit_d;

   logic [NUM_ORDERS-1:0] free_oh;
   logic [NUM_ORDERS-1:0] match_oh;
   logic                  free_taken;
   logic                  match_taken;
   logic                  wrap;
   logic [SUM_W-1:0]      acc;
   logic [TIMER_WIDTH-1:0] bonus;

   // Lowest-index free slot and lowest-index live slot holding the served dish
   always_comb begin
      free_oh     = '0;
      match_oh    = '0;
      free_taken  = 1'b0;
      match_taken = 1'b0;
      for (int i = 0; i < NUM_ORDERS; i++) begin
         if (!active_q[i] && !free_taken) begin
            free_oh[i] = 1'b1;
            free_taken = 1'b1;
         end
         if (active_q[i] && (orders_q[i*ORDER_WIDTH +: ORDER_WIDTH] == serve_dish) && !match_taken) begin
            match_oh[i] = 1'b1;
            match_taken = 1'b1;
         end
      end
   end

   // Round FSM plus slot, count and score updates; dropping start_game wipes everything
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      active_d  = active_q;
      orders_d  = orders_q;
      time_d    = time_q;
      done_d    = done_q;
      expired_d = expired_q;
      score_d   = score_q;
      ack_d     = 1'b0;
      hit_d     = 1'b0;
      acc       = SUM_W'(score_q);
      bonus     = '0;
      wrap      = (tick_q == TICK_LAST);

      case (state_q)
         S_IDLE: begin
            // IDLE is always entered through a full clear, so leaving it needs no extra wipe
            if (start_game) state_d = S_RUN;
         end
         S_RUN: begin
            ack_d  = serve_valid;
            tick_d = wrap ? '0 : tick_q + TICK_W'(1);
            if (serve_valid && (|match_oh)) begin
               hit_d = 1'b1;
               if (done_q != 4'hF) done_d = done_q + 4'd1;
               for (int i = 0; i < NUM_ORDERS; i++) begin
                  if (match_oh[i]) bonus = time_q[i*TIMER_WIDTH +: TIMER_WIDTH] >> 2;
               end
               acc = acc + BASE_SUM + SUM_W'(bonus);
               if (acc > SCORE_MAX) acc = SCORE_MAX;
            end
            for (int i = 0; i < NUM_ORDERS; i++) begin
               // A served slot is never also counted as expired
               if (serve_valid && match_oh[i]) begin
                  active_d[i]                                = 1'b0;
                  orders_d[i*ORDER_WIDTH +: ORDER_WIDTH]     = '0;
                  time_d[i*TIMER_WIDTH +: TIMER_WIDTH]       = '0;
               end else if (wrap && active_q[i] && (time_q[i*TIMER_WIDTH +: TIMER_WIDTH] != '0)) begin
                  if (time_q[i*TIMER_WIDTH +: TIMER_WIDTH] == TIMER_WIDTH'(1)) begin
                     active_d[i]                            = 1'b0;
                     orders_d[i*ORDER_WIDTH +: ORDER_WIDTH] = '0;
                     time_d[i*TIMER_WIDTH +: TIMER_WIDTH]   = '0;
                     if (expired_d != 4'hF) expired_d = expired_d + 4'd1;
                     acc = (acc >= PEN_SUM) ? acc - PEN_SUM : '0;
                  end else begin
                     time_d[i*TIMER_WIDTH +: TIMER_WIDTH] = time_q[i*TIMER_WIDTH +: TIMER_WIDTH] - TIMER_WIDTH'(1);
                  end
               end
               // Free slot comes from the registered flags, so same-cycle frees are reused next cycle
               if (load_valid && free_oh[i]) begin
                  active_d[i]                            = 1'b1;
                  orders_d[i*ORDER_WIDTH +: ORDER_WIDTH] = load_order;
                  time_d[i*TIMER_WIDTH +: TIMER_WIDTH]   = T_LOAD;
               end
            end
            score_d = acc[SCORE_WIDTH-1:0];
            if (done_q >= DONE_WIN) state_d = S_OVER;
         end
         S_OVER: begin
            ack_d = serve_valid;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (!start_game) begin
         state_d   = S_IDLE;
         tick_d    = '0;
         active_d  = '0;
         orders_d  = '0;
         time_d    = '0;
         done_d    = '0;
         expired_d = '0;
         score_d   = '0;
         ack_d     = 1'b0;
         hit_d     = 1'b0;
      end
   end

   // State registers with asynchronous clear to the IDLE values
   always_ff @(posedge basys_clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         tick_q    <= '0;
         active_q  <= '0;
         orders_q  <= '0;
         time_q    <= '0;
         done_q    <= '0;
         expired_q <= '0;
         score_q   <= '0;
         ack_q     <= 1'b0;
         hit_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         active_q  <= active_d;
         orders_q  <= orders_d;
         time_q    <= time_d;
         done_q    <= done_d;
         expired_q <= expired_d;
         score_q   <= score_d;
         ack_q     <= ack_d;
         hit_q     <= hit_d;
      end
   end

   assign load_ready     = (state_q == S_RUN) && (|(~active_q));
   assign serve_ack      = ack_q;
   assign serve_hit      = hit_q;
   assign orders_flat    = orders_q;
   assign active         = active_q;
   assign time_left_flat = time_q;
   assign orders_done    = done_q;
   assign orders_expired = expired_q;
   assign score          = score_q;
   assign game_over      = (state_q == S_OVER);

endmodule

// File: tb/tb_order_tracker.sv
// tb/tb_order_tracker.sv - scoreboard bench for order_tracker against a slot-level reference model
module tb_order_tracker;

   localparam int NO = 3;
   localparam int OW = 12;
   localparam int TW = 7;
   localparam int SW = 8;
   localparam int TD = 4;
   localparam int OT = 3;
   localparam int WT = 2;
   localparam int BP = 10;
   localparam int PN = 5;

   logic              clk;
   logic              reset;
   logic              start_game;
   logic              load_valid;
   logic [OW-1:0]     load_order;
   logic              load_ready;
   logic              serve_valid;
   logic [OW-1:0]     serve_dish;
   logic              serve_ack;
   logic              serve_hit;
   logic [NO*OW-1:0]  orders_flat;
   logic [NO-1:0]     active;
   logic [NO*TW-1:0]  time_left_flat;
   logic [3:0]        orders_done;
   logic [3:0]        orders_expired;
   logic [SW-1:0]     score;
   logic              game_over;

   order_tracker #(
      .NUM_ORDERS(NO), .ORDER_WIDTH(OW), .TICK_DIV(TD), .ORDER_TIME(OT),
      .TIMER_WIDTH(TW), .SCORE_WIDTH(SW), .BASE_POINTS(BP), .PENALTY(PN), .WIN_TARGET(WT)
   ) dut (
      .basys_clk(clk), .reset(reset), .start_game(start_game),
      .load_valid(load_valid), .load_order(load_order), .load_ready(load_ready),
      .serve_valid(serve_valid), .serve_dish(serve_dish), .serve_ack(serve_ack), .serve_hit(serve_hit),
      .orders_flat(orders_flat), .active(active), .time_left_flat(time_left_flat),
      .orders_done(orders_done), .orders_expired(orders_expired), .score(score), .game_over(game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NO*OW-1:0] ord;
      logic [NO-1:0]    act;
      logic [NO*TW-1:0] tl;
      logic [3:0]       done;
      logic [3:0]       expd;
      logic [SW-1:0]    scr;
      logic             over;
      logic             ready;
   } snap_t;

   typedef struct {
      int   due;
      logic hit;
   } ack_t;

   snap_t snap_q[$];
   ack_t  ack_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: phase 0 idle, 1 running, 2 over
   int            m_phase;
   int            m_tick;
   int            m_done;
   int            m_exp;
   int            m_score;
   bit            m_act [NO];
   logic [OW-1:0] m_ord [NO];
   int            m_time[NO];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      m_phase = 0; m_tick = 0; m_done = 0; m_exp = 0; m_score = 0;
      for (int i = 0; i < NO; i++) begin
         m_act[i] = 1'b0; m_ord[i] = '0; m_time[i] = 0;
      end
   endtask

   task automatic model_step(input logic rst, input logic st, input logic lv, input logic [OW-1:0] lo,
                             input logic sv, input logic [OW-1:0] sd);
      int   fs;
      int   hs;
      bit   wrap;
      bit   go_over;
      ack_t a;
      if (rst) begin
         model_clear();
         ack_q.delete();
         return;
      end
      if (!st) begin
         model_clear();
         return;
      end
      if (m_phase == 0) begin
         m_phase = 1;
         return;
      end
      if (m_phase == 2) begin
         if (sv) begin a.due = cyc + 1; a.hit = 1'b0; ack_q.push_back(a); end
         return;
      end
      go_over = (m_done >= WT);
      fs = -1;
      for (int i = 0; i < NO; i++) if (!m_act[i]) begin fs = i; break; end
      hs = -1;
      if (sv) for (int i = 0; i < NO; i++) if (m_act[i] && m_ord[i] == sd) begin hs = i; break; end
      wrap   = (m_tick == TD - 1);
      m_tick = (m_tick + 1) % TD;
      if (hs >= 0) begin
         m_score = m_score + BP + m_time[hs] / 4;
         if (m_score > 255) m_score = 255;
         if (m_done < 15) m_done++;
         m_act[hs] = 1'b0; m_ord[hs] = '0; m_time[hs] = 0;
      end
      if (wrap) begin
         for (int i = 0; i < NO; i++) begin
            if (m_act[i]) begin
               m_time[i]--;
               if (m_time[i] == 0) begin
                  m_act[i] = 1'b0; m_ord[i] = '0;
                  if (m_exp < 15) m_exp++;
                  m_score = (m_score > PN) ? m_score - PN : 0;
               end
            end
         end
      end
      if (lv && fs >= 0) begin
         m_act[fs] = 1'b1; m_ord[fs] = lo; m_time[fs] = OT;
      end
      if (sv) begin a.due = cyc + 1; a.hit = (hs >= 0); ack_q.push_back(a); end
      if (go_over) m_phase = 2;
   endtask

   function automatic snap_t make_snap();
      snap_t s;
      bit    any_free;
      s.ord = '0; s.act = '0; s.tl = '0;
      any_free = 1'b0;
      for (int i = 0; i < NO; i++) begin
         if (m_act[i]) begin
            s.ord[i*OW +: OW] = m_ord[i];
            s.act[i]          = 1'b1;
            s.tl[i*TW +: TW]  = TW'(m_time[i]);
         end else begin
            any_free = 1'b1;
         end
      end
      s.done  = 4'(m_done);
      s.expd  = 4'(m_exp);
      s.scr   = SW'(m_score);
      s.over  = (m_phase == 2);
      s.ready = (m_phase == 1) && any_free;
      return s;
   endfunction

   // Drive one cycle of stimulus on the falling edge and queue the expected results
   task automatic cycle(input logic st, input logic lv, input logic [OW-1:0] lo,
                        input logic sv, input logic [OW-1:0] sd, input logic rst);
      @(negedge clk);
      reset       = rst;
      start_game  = st;
      load_valid  = lv;
      load_order  = lo;
      serve_valid = sv;
      serve_dish  = sd;
      model_step(rst, st, lv, lo, sv, sd);
      snap_q.push_back(make_snap());
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compares registered outputs each cycle and pops an ack expectation per serve_ack
   initial begin
      snap_t s;
      ack_t  a;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (snap_q.size() != 0) begin
            s = snap_q.pop_front();
            chk("orders_flat", orders_flat, s.ord);
            chk("active", active, s.act);
            chk("time_left_flat", time_left_flat, s.tl);
            chk("orders_done", orders_done, s.done);
            chk("orders_expired", orders_expired, s.expd);
            chk("score", score, s.scr);
            chk("game_over", game_over, s.over);
            chk("load_ready", load_ready, s.ready);
         end
         if (serve_ack) begin
            if (ack_q.size() == 0) begin
               chk("serve_ack_unexpected", 1, 0);
            end else begin
               a = ack_q.pop_front();
               chk("serve_ack_cycle", a.due, cyc);
               chk("serve_hit", serve_hit, a.hit);
            end
         end else if (ack_q.size() != 0 && ack_q[0].due <= cyc) begin
            chk("serve_ack_missing", 0, 1);
            void'(ack_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [OW-1:0] pool [6];
      logic          rst, st, lv, sv;
      logic [OW-1:0] lo, sd;
      pool[0] = 12'h012; pool[1] = 12'h034; pool[2] = 12'h056;
      pool[3] = 12'h078; pool[4] = 12'h0AB; pool[5] = 12'hFFF;

      reset = 1'b1; start_game = 1'b0; load_valid = 1'b0; load_order = '0;
      serve_valid = 1'b0; serve_dish = '0;
      model_clear();

      repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      settle();
      chk("dir_ready_after_start", load_ready, 1);
      chk("dir_score_after_start", score, 0);

      cycle(1'b1, 1'b1, 12'h012, 1'b0, '0, 1'b0);
      cycle(1'b1, 1'b1, 12'h034, 1'b0, '0, 1'b0);
      cycle(1'b1, 1'b1, 12'h056, 1'b0, '0, 1'b0);
      settle();
      chk("dir_full_active", active, 3'b111);
      chk("dir_full_ready", load_ready, 0);
      cycle(1'b1, 1'b1, 12'h078, 1'b0, '0, 1'b0);
      settle();
      chk("dir_fourth_dropped", orders_flat, 36'h056034012);

      cycle(1'b1, 1'b0, '0, 1'b1, 12'h034, 1'b0);
      settle();
      chk("dir_hit_ack", serve_ack, 1);
      chk("dir_hit_flag", serve_hit, 1);
      chk("dir_hit_done", orders_done, 1);
      chk("dir_hit_score", score, 10);
      chk("dir_hit_active", active, 3'b101);

      cycle(1'b1, 1'b0, '0, 1'b1, 12'h0FF, 1'b0);
      settle();
      chk("dir_miss_ack", serve_ack, 1);
      chk("dir_miss_flag", serve_hit, 0);
      chk("dir_miss_active", active, 3'b101);

      repeat (12) cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      settle();
      chk("dir_expired_count", orders_expired, 2);
      chk("dir_expired_score", score, 0);
      chk("dir_expired_active", active, 3'b000);

      cycle(1'b1, 1'b1, 12'h0AB, 1'b0, '0, 1'b0);
      cycle(1'b1, 1'b0, '0, 1'b1, 12'h0AB, 1'b0);
      settle();
      chk("dir_win_done", orders_done, 2);
      chk("dir_win_not_over_yet", game_over, 0);
      cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      settle();
      chk("dir_game_over", game_over, 1);
      cycle(1'b1, 1'b1, 12'h012, 1'b1, 12'h0AB, 1'b0);
      settle();
      chk("dir_over_load_ignored", active, 3'b000);
      chk("dir_over_ack", serve_ack, 1);
      chk("dir_over_hit", serve_hit, 0);
      cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      settle();
      chk("dir_idle_done", orders_done, 0);
      chk("dir_idle_over", game_over, 0);
      chk("dir_idle_score", score, 0);

      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(149) == 0);
         st  = ($urandom_range(24) != 0);
         lv  = ($urandom_range(4) < 2);
         lo  = pool[$urandom_range(4)];
         sv  = ($urandom_range(2) == 0);
         sd  = pool[$urandom_range(5)];
         if (rst) begin
            lv = 1'b0;
            sv = 1'b0;
         end
         cycle(st, lv, lo, sv, sd, rst);
      end

      repeat (3) cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      settle();
      #5;
      chk("scoreboard_snap_drained", snap_q.size(), 0);
      chk("scoreboard_ack_drained", ack_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
